// File: rtl/alu_vec_pipe.sv
// Two-stage fixed-point vector ALU (mul/sub/add, optional saturation) with
// valid/ready on both sides. Each lane owns its operand and result registers;
// the top owns the shared control, the valid shift register and the handshake.

module alu_vec_lane #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s1_en,
  input  logic              s2_en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  input  logic              sat_en,
  input  logic              active,
  output logic [DATA_W-1:0] res,
  output logic [3:0]        flg
);
  localparam int PW = 2 * DATA_W;
  localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [PW-1:0]     MAX_W   = {{DATA_W{1'b0}}, MAX_POS};
  localparam logic [PW-1:0]     MIN_W   = {{DATA_W{1'b0}}, MIN_NEG};

  // Sign-magnitude operands; magnitude of the most negative value is 2^(DATA_W-1).
  logic [DATA_W-1:0] mag_a, mag_b;
  logic [PW-1:0]     wa, wb;
  assign mag_a = a[DATA_W-1] ? (~a + 1'b1) : a;
  assign mag_b = b[DATA_W-1] ? (~b + 1'b1) : b;
  assign wa    = {{DATA_W{1'b0}}, mag_a};
  assign wb    = {{DATA_W{1'b0}}, mag_b};

  logic [DATA_W-1:0] s1_a, s1_b;
  logic              s1_neg;
  logic [PW-1:0]     s1_prod;

  // Stage 1: operands, product sign and full-width magnitude product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_a    <= '0;
      s1_b    <= '0;
      s1_neg  <= 1'b0;
      s1_prod <= '0;
    end else if (s1_en) begin
      s1_a    <= a;
      s1_b    <= b;
      s1_neg  <= a[DATA_W-1] ^ b[DATA_W-1];
      s1_prod <= wa * wb;
    end
  end

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] nb, wrap, fin;
  logic [PW-1:0]     shifted;
  logic              c, v, pos;
  logic [DATA_W-1:0] res_c;
  logic [3:0]        flg_c;

  assign nb      = ~s1_b + 1'b1;
  assign shifted = s1_prod >> FRAC_W;

  // Stage 2 combinational: wrap value, C/V, then saturation and Z/N on the final value.
  always_comb begin
    sum  = '0;
    wrap = '0;
    c    = 1'b0;
    v    = 1'b0;
    pos  = 1'b0;
    case (op)
      3'b000: begin
        v    = (shifted > MAX_W) && !(s1_neg && (shifted == MIN_W));
        wrap = s1_neg ? (~shifted[DATA_W-1:0] + 1'b1) : shifted[DATA_W-1:0];
        pos  = !s1_neg;
      end
      3'b001: begin
        sum  = {1'b0, s1_a} + {1'b0, nb};
        wrap = sum[DATA_W-1:0];
        c    = sum[DATA_W];
        v    = (s1_a[DATA_W-1] != s1_b[DATA_W-1]) && (wrap[DATA_W-1] != s1_a[DATA_W-1]);
        pos  = !s1_a[DATA_W-1];
      end
      3'b010: begin
        sum  = {1'b0, s1_a} + {1'b0, s1_b};
        wrap = sum[DATA_W-1:0];
        c    = sum[DATA_W];
        v    = (s1_a[DATA_W-1] == s1_b[DATA_W-1]) && (wrap[DATA_W-1] != s1_a[DATA_W-1]);
        pos  = !s1_a[DATA_W-1];
      end
      default: ;
    endcase
    fin = (v && sat_en) ? (pos ? MAX_POS : MIN_NEG) : wrap;
    if (active) begin
      res_c = fin;
      flg_c = {v, fin[DATA_W-1], (fin == '0), c};
    end else begin
      res_c = '0;
      flg_c = '0;
    end
  end

  // Stage 2 registers drive the outputs directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res <= '0;
      flg <= '0;
    end else if (s2_en) begin
      res <= res_c;
      flg <= flg_c;
    end
  end
endmodule

module alu_vec_pipe #(
  parameter int NUM_LANES = 4,
  parameter int DATA_W    = 16,
  parameter int FRAC_W    = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2:0]                    opcode,
  input  logic                          flag_scalar,
  input  logic                          sat_en,
  input  logic [NUM_LANES*DATA_W-1:0]   data_a,
  input  logic [NUM_LANES*DATA_W-1:0]   data_b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_LANES*DATA_W-1:0]   result,
  output logic [NUM_LANES*4-1:0]        flags
);
  typedef struct packed {
    logic [2:0] op;
    logic       sat;
    logic       scalar;
  } ctl_t;

  ctl_t s1_ctl;
  logic [2:1] vld_pipe;
  logic       s1_load, s2_load;

  logic [NUM_LANES-1:0][DATA_W-1:0] a_l, b_l, res_l;
  logic [NUM_LANES-1:0][3:0]        flg_l;

  assign a_l    = data_a;
  assign b_l    = data_b;
  assign result = res_l;
  assign flags  = flg_l;

  // S2 refills whenever its contents are gone or leaving; S1 follows it.
  assign out_valid = vld_pipe[2];
  assign s2_load   = !vld_pipe[2] || out_ready;
  assign in_ready  = !vld_pipe[1] || s2_load;
  assign s1_load   = in_valid && in_ready;

  // Valid shift register; reset flushes everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else begin
      if (in_ready) vld_pipe[1] <= in_valid;
      if (s2_load)  vld_pipe[2] <= vld_pipe[1];
    end
  end

  // Shared per-op control captured alongside the lane operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s1_ctl <= '0;
    else if (s1_load) s1_ctl <= '{op: opcode, sat: sat_en, scalar: flag_scalar};
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    alu_vec_lane #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .s1_en  (s1_load),
      .s2_en  (s2_load && vld_pipe[1]),
      .a      (a_l[i]),
      .b      (b_l[i]),
      .op     (s1_ctl.op),
      .sat_en (s1_ctl.sat),
      .active ((i == 0) || !s1_ctl.scalar),
      .res    (res_l[i]),
      .flg    (flg_l[i])
    );
  end
endmodule

// File: tb/tb_alu_vec_pipe.sv
// Directed bench for alu_vec_pipe: per-op vectors, streaming with back-pressure,
// and reset while both stages hold data.

module tb_alu_vec_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flag_scalar, sat_en, out_valid, out_ready;
  logic [2:0]  opcode;
  logic [63:0] data_a, data_b, result;
  logic [15:0] flags;

  int n_chk = 0;
  int n_err = 0;

  alu_vec_pipe #(.NUM_LANES(4), .DATA_W(16), .FRAC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .flag_scalar(flag_scalar), .sat_en(sat_en),
    .data_a(data_a), .data_b(data_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_one(input logic [2:0] op, input logic sc, input logic sat,
                          input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    opcode = op; flag_scalar = sc; sat_en = sat; data_a = a; data_b = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_dir(input string tag, input logic [2:0] op, input logic sc,
                         input logic sat, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] er, input logic [15:0] ef);
    send_one(op, sc, sat, a, b);
    @(negedge clk);
    chk({tag, "_lat1"}, {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    chk({tag, "_vld"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_res"}, result, er);
    chk({tag, "_flg"}, {48'd0, flags}, {48'd0, ef});
  endtask

  logic [3:0]  pat = 4'b1001;
  int          sent, rcv;
  logic        prev_stall, in_fire, out_fire;
  logic [63:0] prev_res;
  logic [15:0] prev_flg;
  logic [15:0] lv;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; opcode = '0;
    flag_scalar = 1'b0; sat_en = 1'b0; data_a = '0; data_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_flags", {48'd0, flags}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Q8.8 multiply: simple, negative, overflow, exact -2^15 (no V)
    run_dir("mul_wrap", 3'b000, 1'b0, 1'b0,
            {16'h8000, 16'h4000, 16'hFE80, 16'h0180}, {16'h0100, 16'h4000, 16'h0200, 16'h0200},
            {16'h8000, 16'h0000, 16'hFD00, 16'h0300}, {4'b0100, 4'b1010, 4'b0100, 4'b0000});
    run_dir("mul_sat", 3'b000, 1'b0, 1'b1,
            {16'h8000, 16'h4000, 16'hFE80, 16'h0180}, {16'h0100, 16'h4000, 16'h0200, 16'h0200},
            {16'h8000, 16'h7FFF, 16'hFD00, 16'h0300}, {4'b0100, 4'b1000, 4'b0100, 4'b0000});
    // add: positive overflow, negative overflow with carry, plain, carry to zero
    run_dir("add_wrap", 3'b010, 1'b0, 1'b0,
            {16'hFFFF, 16'h0100, 16'h8000, 16'h7F00}, {16'h0001, 16'h0200, 16'hFF00, 16'h0200},
            {16'h0000, 16'h0300, 16'h7F00, 16'h8100}, {4'b0011, 4'b0000, 4'b1001, 4'b1100});
    run_dir("add_sat", 3'b010, 1'b0, 1'b1,
            {16'hFFFF, 16'h0100, 16'h8000, 16'h7F00}, {16'h0001, 16'h0200, 16'hFF00, 16'h0200},
            {16'h0000, 16'h0300, 16'h8000, 16'h7FFF}, {4'b0011, 4'b0000, 4'b1101, 4'b1000});
    // sub: equal operands, negative overflow saturated, borrow, zero minus zero
    run_dir("sub_sat", 3'b001, 1'b0, 1'b1,
            {16'h0000, 16'h0100, 16'h8000, 16'h0100}, {16'h0000, 16'h0200, 16'h0100, 16'h0100},
            {16'h0000, 16'hFF00, 16'h8000, 16'h0000}, {4'b0010, 4'b0100, 4'b1101, 4'b0011});
    run_dir("bad_op", 3'b111, 1'b0, 1'b1,
            {4{16'h7F00}}, {4{16'h0200}}, 64'd0, {4{4'b0010}});
    run_dir("scalar", 3'b010, 1'b1, 1'b0,
            {4{16'h0100}}, {4{16'h0100}}, {48'd0, 16'h0200}, 16'h0000);

    // Streaming: 8 back-to-back adds, out_ready pattern 1,0,0,1 repeating
    sent = 0; rcv = 0; prev_stall = 1'b0; prev_res = '0; prev_flg = '0;
    opcode = 3'b010; flag_scalar = 1'b0; sat_en = 1'b0;
    for (int c = 0; c < 80 && rcv < 8; c++) begin
      @(negedge clk);
      out_ready = pat[c % 4];
      in_valid  = (sent < 8);
      lv        = 16'((sent + 1) * 256);
      data_a    = {4{lv}};
      data_b    = {4{16'h0001}};
      #1;
      chk("b2b_in_ready", {63'd0, in_ready}, {63'd0, !((sent - rcv) == 2 && !out_ready)});
      if (prev_stall) begin
        chk("b2b_hold_vld", {63'd0, out_valid}, 64'd1);
        chk("b2b_hold_res", result, prev_res);
        chk("b2b_hold_flg", {48'd0, flags}, {48'd0, prev_flg});
      end
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      if (out_fire) begin
        lv = 16'((rcv + 1) * 256 + 1);
        chk("b2b_res", result, {4{lv}});
        chk("b2b_flg", {48'd0, flags}, 64'd0);
      end
      prev_stall = out_valid && !out_ready;
      prev_res   = result;
      prev_flg   = flags;
      @(posedge clk);
      if (in_fire)  sent++;
      if (out_fire) rcv++;
    end
    chk("b2b_count", 64'(rcv), 64'd8);
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("b2b_drained", {63'd0, out_valid}, 64'd0);

    // Fill both stages with out_ready low, then reset mid-flight
    @(negedge clk);
    out_ready = 1'b0; opcode = 3'b010; data_a = {4{16'h0100}}; data_b = {4{16'h0100}};
    in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("full_out_valid", {63'd0, out_valid}, 64'd1);
    chk("full_in_ready", {63'd0, in_ready}, 64'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_result", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("postrst_no_stale", {63'd0, out_valid}, 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
